// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a start/busy/done handshake.
// Single-cycle ops (add/sub/logic/compare/shift) finish one cycle after start.
// When the SEQ_ALU_MULDIV_EN macro is defined, mul/divu/remu run iteratively:
// one bit per cycle, WIDTH cycles in RUN, then DONE.
// Without the macro, codes 1000-1010 behave like any undefined code (result 0)
// and the RUN state is not built.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [3:0]       ALUControl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
`ifdef SEQ_ALU_MULDIV_EN
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;
    localparam int         CNTW    = $clog2(WIDTH);
`endif

    // Result of every op that completes in the launch cycle. With mul/div
    // enabled this also covers divide-by-zero, which skips iteration.
    function automatic logic [WIDTH-1:0] alu_single(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  r = a << b[SHW-1:0];
`ifdef SEQ_ALU_MULDIV_EN
            // Only reached with b == 0: quotient saturates, remainder is a.
            OP_DIVU: r = {WIDTH{1'b1}};
            OP_REMU: r = a;
`endif
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] result_s;
    logic             zero_r;
    logic             done_r;

`ifdef SEQ_ALU_MULDIV_EN
    // acc_r: partial product (mul) or partial remainder (div).
    // opa_r: shifted multiplicand (mul) or dividend/quotient shift register (div).
    // opb_r: shifted multiplier (mul) or divisor (div).
    logic [CNTW-1:0]  cnt_r;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic             busy_r;
    logic [WIDTH-1:0] acc_nx_s;
    logic [WIDTH-1:0] opa_nx_s;
    logic [WIDTH-1:0] opb_nx_s;
    logic [WIDTH-1:0] iter_res_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   diff_s;
    logic             launch_iter_s;

    // Decide whether an accepted start goes through the iterative path.
    always_comb begin
        launch_iter_s = 1'b0;
        if (((ALUControl == OP_MUL) || (ALUControl == OP_DIVU) || (ALUControl == OP_REMU))
            && (SrcB != {WIDTH{1'b0}})) begin
            launch_iter_s = 1'b1;
        end else begin
            launch_iter_s = 1'b0;
        end
    end

    // One shift-add multiply step or one restoring divide step.
    always_comb begin
        shifted_s  = {acc_r, opa_r[WIDTH-1]};
        diff_s     = shifted_s - {1'b0, opb_r};
        acc_nx_s   = acc_r;
        opa_nx_s   = opa_r;
        opb_nx_s   = opb_r;
        iter_res_s = {WIDTH{1'b0}};
        if (op_r == OP_MUL) begin
            acc_nx_s = opb_r[0] ? (acc_r + opa_r) : acc_r;
            opa_nx_s = opa_r << 1;
            opb_nx_s = opb_r >> 1;
        end else if (!diff_s[WIDTH]) begin
            // Trial subtraction fits: keep it and shift in a quotient 1.
            acc_nx_s = diff_s[WIDTH-1:0];
            opa_nx_s = {opa_r[WIDTH-2:0], 1'b1};
        end else begin
            // Restore: keep the shifted remainder and shift in a quotient 0.
            acc_nx_s = shifted_s[WIDTH-1:0];
            opa_nx_s = {opa_r[WIDTH-2:0], 1'b0};
        end
        case (op_r)
            OP_MUL:  iter_res_s = acc_nx_s;
            OP_DIVU: iter_res_s = opa_nx_s;
            default: iter_res_s = acc_nx_s;
        endcase
    end

    // Iteration registers: load on launch, step while in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNTW{1'b0}};
            op_r  <= 4'b0000;
            acc_r <= {WIDTH{1'b0}};
            opa_r <= {WIDTH{1'b0}};
            opb_r <= {WIDTH{1'b0}};
        end else if (((state_r == ST_IDLE) || (state_r == ST_DONE)) && start && launch_iter_s) begin
            cnt_r <= CNTW'(WIDTH - 1);
            op_r  <= ALUControl;
            acc_r <= {WIDTH{1'b0}};
            opa_r <= SrcA;
            opb_r <= SrcB;
        end else if (state_r == ST_RUN) begin
            cnt_r <= cnt_r - CNTW'(1);
            acc_r <= acc_nx_s;
            opa_r <= opa_nx_s;
            opb_r <= opb_nx_s;
        end
    end

    // busy is registered from the next state so it tracks RUN exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_s == ST_RUN);
        end
    end

    assign busy = busy_r;
`else
    assign busy = 1'b0;
`endif

    // Next-state and next-result selection for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_s  = state_r;
        result_s = result_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
`ifdef SEQ_ALU_MULDIV_EN
                    if (launch_iter_s) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s  = ST_DONE;
                        result_s = alu_single(ALUControl, SrcA, SrcB);
                    end
`else
                    state_s  = ST_DONE;
                    result_s = alu_single(ALUControl, SrcA, SrcB);
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
`ifdef SEQ_ALU_MULDIV_EN
            ST_RUN: begin
                if (cnt_r == {CNTW{1'b0}}) begin
                    state_s  = ST_DONE;
                    result_s = iter_res_s;
                end else begin
                    state_s = ST_RUN;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, result, Zero and done registers; result only moves on DONE entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            result_r <= {WIDTH{1'b0}};
            zero_r   <= 1'b1;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            result_r <= result_s;
            zero_r   <= (result_s == {WIDTH{1'b0}});
            done_r   <= (state_s == ST_DONE);
        end
    end

    assign done      = done_r;
    assign ALUResult = result_r;
    assign Zero      = zero_r;

endmodule
